// File: rtl/dsc_pkg.sv
// Purpose: shared widths, FSM states and stream helpers for the DSC multiplier.
// Latency: n/a (types, constants and combinational functions only).
// Backpressure: n/a.
package dsc_pkg;

  localparam int OP_W   = 4;
  localparam int Z_W    = 8;
  localparam int SN_LEN = 16;
  localparam int PC_W   = $clog2(SN_LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Thermometer code: the lowest v bits are set, the rest are clear.
  function automatic logic [SN_LEN-1:0] therm(input logic [OP_W-1:0] v);
    logic [SN_LEN-1:0] t;
    t = '0;
    for (int i = 0; i < SN_LEN; i++) begin
      t[i] = (i < int'(v));
    end
    return t;
  endfunction

  // Number of ones in a stream.
  function automatic logic [PC_W-1:0] popcount(input logic [SN_LEN-1:0] s);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < SN_LEN; i++) begin
      n = n + PC_W'(s[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/dsc_mul_counter.sv
// Purpose: free-running wrap-around up-counter with a combinational overflow strobe.
// Latency: out updates one edge after en; overflow is same-cycle combinational.
// Backpressure: en=0 freezes the count.
module counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             overflow
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;

  // Increment when enabled; natural wrap from all-ones back to zero.
  always_comb begin
    out_d = out_q;
    if (en) begin
      out_d = out_q + WIDTH'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out      = out_q;
  assign overflow = en && (out_q == {WIDTH{1'b1}});

endmodule

// File: rtl/dsc_mul.sv
// Purpose: 4x4 unsigned multiply via deterministic unary bitstreams (a stream in parallel, b serially).
// Latency: 17 enabled edges from IDLE (1 load + 16 run); ov then holds until reset.
// Backpressure: en=0 freezes every register; a new operation needs a reset.
module dsc_mul
  import dsc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  output logic [Z_W-1:0]  z,
  output logic            ov
);

  state_t              state_q, state_d;
  logic [SN_LEN-1:0]   ta_q, ta_d;
  logic [SN_LEN-1:0]   tb_q, tb_d;
  logic [Z_W-1:0]      acc_q, acc_d;
  logic [OP_W-1:0]     j;
  logic                j_en;
  logic                j_ovf;

  // j only moves in RUN, so it is already zero whenever IDLE loads new operands.
  assign j_en = en && (state_q == RUN);

  counter #(
    .WIDTH(OP_W)
  ) u_step (
    .clk      (clk),
    .rst      (rst),
    .en       (j_en),
    .out      (j),
    .overflow (j_ovf)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: load on first enabled edge, finish when the step counter wraps.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en)    state_d = RUN;
      RUN:     if (j_ovf) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: capture streams on load, accumulate popcount(ta) per set b bit.
  always_comb begin
    ta_d  = ta_q;
    tb_d  = tb_q;
    acc_d = acc_q;
    if (en) begin
      case (state_q)
        IDLE: begin
          ta_d  = therm(a);
          tb_d  = therm(b);
          acc_d = '0;
        end
        RUN: begin
          if (tb_q[j]) begin
            acc_d = acc_q + Z_W'(popcount(ta_q));
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers; reset clears any partial result immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ta_q  <= '0;
      tb_q  <= '0;
      acc_q <= '0;
    end else begin
      ta_q  <= ta_d;
      tb_q  <= tb_d;
      acc_q <= acc_d;
    end
  end

  // Outputs: accumulator is always visible, done flag decoded from state.
  always_comb begin
    z  = acc_q;
    ov = (state_q == DONE);
  end

endmodule

// File: tb/tb_dsc_mul.sv
// Purpose: self-checking bench for dsc_mul with a product/latency scoreboard.
// Latency: expects ov on edge 17 + pause cycles after start.
// Backpressure: exercises en pauses and operand changes during RUN.
module tb_dsc_mul;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] z;
  logic       ov;

  int vectors;
  int miscompares;
  int exp_z_q[$];
  int exp_lat_q[$];
  int lat_sum;

  dsc_mul dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .a   (a),
    .b   (b),
    .z   (z),
    .ov  (ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Assert reset between edges, check outputs clear without a clock, then release.
  task automatic do_reset();
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_z", int'(z), 0);
    chk("rst_ov", int'(ov), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Start one multiply; en low for plen cycles from cycle pstart; optionally
  // change operands to 15 at cycle chg_at. Scoreboard is pushed at drive time.
  task automatic run_op(input int av, input int bv, input int pstart, input int plen,
                        input int chg_at, input bit hold_chk);
    int edges;
    int ez;
    int el;
    bit seen;
    exp_z_q.push_back(av * bv);
    exp_lat_q.push_back(17 + plen);
    seen  = 1'b0;
    edges = 0;
    a = 4'(av);
    b = 4'(bv);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      en = !(c >= pstart && c < pstart + plen);
      if (c == chg_at) begin
        a = 4'd15;
        b = 4'd15;
      end
      @(posedge clk);
      #1;
      edges = c + 1;
      if (ov) begin
        seen = 1'b1;
        break;
      end
    end
    chk("ov_timeout", int'(ov), 1);
    if (seen) begin
      ez = exp_z_q.pop_front();
      el = exp_lat_q.pop_front();
      chk("product", int'(z), ez);
      chk("latency", edges, el);
      lat_sum += edges;
      if (hold_chk) begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          en = k[0];
          a  = 4'(k);
          b  = 4'(15 - k);
          @(posedge clk);
          #1;
          chk("hold_z", int'(z), ez);
          chk("hold_ov", int'(ov), 1);
        end
      end
    end
    @(negedge clk);
    en = 1'b0;
  endtask

  initial begin
    int full_sum;
    vectors     = 0;
    miscompares = 0;
    lat_sum     = 0;
    rst = 1'b0;
    en  = 1'b0;
    a   = '0;
    b   = '0;
    #2;
    chk("por_z", int'(z), 0);
    chk("por_ov", int'(ov), 0);
    @(negedge clk);
    rst = 1'b1;

    // Max operands, then result/flag must hold regardless of en/a/b.
    run_op(15, 15, 1000, 0, -1, 1'b1);

    do_reset(); run_op(0, 9, 1000, 0, -1, 1'b0);
    do_reset(); run_op(7, 1, 1000, 0, -1, 1'b0);
    do_reset(); run_op(1, 15, 1000, 0, -1, 1'b0);

    // Five-cycle pause in the middle of RUN.
    do_reset(); run_op(12, 10, 8, 5, -1, 1'b0);

    // Abort mid-RUN: load edge plus 8 run edges, then asynchronous reset.
    do_reset();
    a  = 4'd9;
    b  = 4'd6;
    en = 1'b1;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_z", int'(z), 0);
    chk("abort_ov", int'(ov), 0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_op(3, 5, 1000, 0, -1, 1'b0);

    // Operands change during RUN must be ignored.
    do_reset(); run_op(5, 5, 1000, 0, 4, 1'b0);

    // Exhaustive sweep; average latency must be exactly 17.
    lat_sum = 0;
    for (int i = 0; i < 256; i++) begin
      do_reset();
      run_op(i / 16, i % 16, 1000, 0, -1, 1'b0);
    end
    full_sum = 17 * 256;
    chk("avg_latency_x256", lat_sum, full_sum);
    chk("scoreboard_empty", exp_z_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
